// File: rtl/baccarat_round_ctrl.sv
// Baccarat round controller: deals, scores and judges complete rounds
// back-to-back, keeping saturating win/tie/round tallies.
module baccarat_round_ctrl #(
    parameter int TALLY_W     = 8,
    parameter bit BANKER_RULE = 1'b1
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               step,
    input  logic               auto_mode,
    input  logic [3:0]         new_card,
    output logic [3:0]         pcard1,
    output logic [3:0]         pcard2,
    output logic [3:0]         pcard3,
    output logic [3:0]         dcard1,
    output logic [3:0]         dcard2,
    output logic [3:0]         dcard3,
    output logic [3:0]         pscore,
    output logic [3:0]         dscore,
    output logic               player_win,
    output logic               dealer_win,
    output logic               round_done,
    output logic [TALLY_W-1:0] pwins,
    output logic [TALLY_W-1:0] dwins,
    output logic [TALLY_W-1:0] ties,
    output logic [TALLY_W-1:0] rounds
);

    typedef enum logic [2:0] {
        P1, D1, P2, D2, EVAL, BANK, DONE
    } state_t;

    localparam logic [TALLY_W-1:0] TMAX = '1;

    state_t     state;
    logic       adv;
    logic [3:0] nv;
    logic [3:0] pv;
    logic [3:0] d_plus;
    logic [3:0] fin_d;
    logic       natural;
    logic       bank_draw;
    logic       finish;
    logic       draw_d;

    function automatic logic [3:0] val(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
    endfunction

    function automatic logic [3:0] mod10(input logic [4:0] s);
        if (s >= 5'd20)
            return 4'(s - 5'd20);
        else if (s >= 5'd10)
            return 4'(s - 5'd10);
        else
            return s[3:0];
    endfunction

    assign adv    = step | auto_mode;
    assign nv     = val(new_card);
    assign pv     = val(pcard3);
    assign pscore = mod10({1'b0, val(pcard1)} + {1'b0, val(pcard2)}
                          + {1'b0, val(pcard3)});
    assign dscore = mod10({1'b0, val(dcard1)} + {1'b0, val(dcard2)}
                          + {1'b0, val(dcard3)});
    assign d_plus = mod10({1'b0, dscore} + {1'b0, nv});
    assign natural = (pscore >= 4'd8) || (dscore >= 4'd8);

    always_comb begin
        bank_draw = 1'b0;
        if (BANKER_RULE) begin
            unique case (dscore)
                4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
                4'd3:    bank_draw = (pv != 4'd8);
                4'd4:    bank_draw = (pv >= 4'd2) && (pv <= 4'd7);
                4'd5:    bank_draw = (pv >= 4'd4) && (pv <= 4'd7);
                4'd6:    bank_draw = (pv >= 4'd6) && (pv <= 4'd7);
                default: bank_draw = 1'b0;
            endcase
        end else begin
            bank_draw = (dscore <= 4'd5);
        end
    end

    // Final dealer score must include a third card loaded on this same edge
    always_comb begin
        finish = 1'b0;
        draw_d = 1'b0;
        unique case (state)
            EVAL: begin
                finish = natural || (pscore > 4'd5);
                draw_d = !natural && (pscore > 4'd5) && (dscore <= 4'd5);
            end
            BANK: begin
                finish = 1'b1;
                draw_d = bank_draw;
            end
            default: ;
        endcase
        fin_d = draw_d ? d_plus : dscore;
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state      <= P1;
            pcard1     <= '0;
            pcard2     <= '0;
            pcard3     <= '0;
            dcard1     <= '0;
            dcard2     <= '0;
            dcard3     <= '0;
            player_win <= 1'b0;
            dealer_win <= 1'b0;
            round_done <= 1'b0;
            pwins      <= '0;
            dwins      <= '0;
            ties       <= '0;
            rounds     <= '0;
        end else if (adv) begin
            unique case (state)
                P1: begin
                    pcard1 <= new_card;
                    state  <= D1;
                end
                D1: begin
                    dcard1 <= new_card;
                    state  <= P2;
                end
                P2: begin
                    pcard2 <= new_card;
                    state  <= D2;
                end
                D2: begin
                    dcard2 <= new_card;
                    state  <= EVAL;
                end
                EVAL: begin
                    if (finish) begin
                        state <= DONE;
                    end else begin
                        pcard3 <= new_card;
                        state  <= BANK;
                    end
                end
                BANK: state <= DONE;
                DONE: begin
                    pcard1     <= '0;
                    pcard2     <= '0;
                    pcard3     <= '0;
                    dcard1     <= '0;
                    dcard2     <= '0;
                    dcard3     <= '0;
                    player_win <= 1'b0;
                    dealer_win <= 1'b0;
                    round_done <= 1'b0;
                    state      <= P1;
                end
                default: state <= P1;
            endcase
            if (draw_d)
                dcard3 <= new_card;
            if (finish) begin
                player_win <= (pscore >= fin_d);
                dealer_win <= (fin_d >= pscore);
                round_done <= 1'b1;
                if (pscore > fin_d) begin
                    if (pwins != TMAX)
                        pwins <= pwins + 1'b1;
                end else if (fin_d > pscore) begin
                    if (dwins != TMAX)
                        dwins <= dwins + 1'b1;
                end else begin
                    if (ties != TMAX)
                        ties <= ties + 1'b1;
                end
                if (rounds != TMAX)
                    rounds <= rounds + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Bench for baccarat_round_ctrl: two instances (full banker table / 8-bit
// tallies, simplified rule / 2-bit tallies) driven in lockstep.
module tb_baccarat_round_ctrl;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       step = 1'b0;
    logic       auto_mode = 1'b0;
    logic [3:0] new_card = 4'd0;

    logic [3:0] pc1_a, pc2_a, pc3_a, dc1_a, dc2_a, dc3_a, ps_a, ds_a;
    logic       pw_a, dw_a, rd_a;
    logic [7:0] pwins_a, dwins_a, ties_a, rounds_a;
    logic [3:0] pc1_b, pc2_b, pc3_b, dc1_b, dc2_b, dc3_b, ps_b, ds_b;
    logic       pw_b, dw_b, rd_b;
    logic [1:0] pwins_b, dwins_b, ties_b, rounds_b;

    logic [34:0] snap [2];
    int tp [2];
    int td [2];
    int tt [2];
    int tr [2];

    int total = 0;
    int passed = 0;
    int cards [6];
    int m_pw [2];
    int m_dw [2];
    int m_ti [2];
    int m_rd [2];
    int tmax [2] = '{255, 3};
    int rule [2] = '{1, 0};

    baccarat_round_ctrl #(.TALLY_W(8), .BANKER_RULE(1'b1)) dut_a (
        .slow_clock(clk), .resetb(resetb), .step(step),
        .auto_mode(auto_mode), .new_card(new_card),
        .pcard1(pc1_a), .pcard2(pc2_a), .pcard3(pc3_a),
        .dcard1(dc1_a), .dcard2(dc2_a), .dcard3(dc3_a),
        .pscore(ps_a), .dscore(ds_a),
        .player_win(pw_a), .dealer_win(dw_a), .round_done(rd_a),
        .pwins(pwins_a), .dwins(dwins_a), .ties(ties_a), .rounds(rounds_a)
    );

    baccarat_round_ctrl #(.TALLY_W(2), .BANKER_RULE(1'b0)) dut_b (
        .slow_clock(clk), .resetb(resetb), .step(step),
        .auto_mode(auto_mode), .new_card(new_card),
        .pcard1(pc1_b), .pcard2(pc2_b), .pcard3(pc3_b),
        .dcard1(dc1_b), .dcard2(dc2_b), .dcard3(dc3_b),
        .pscore(ps_b), .dscore(ds_b),
        .player_win(pw_b), .dealer_win(dw_b), .round_done(rd_b),
        .pwins(pwins_b), .dwins(dwins_b), .ties(ties_b), .rounds(rounds_b)
    );

    assign snap[0] = {pc1_a, pc2_a, pc3_a, dc1_a, dc2_a, dc3_a,
                      ps_a, ds_a, pw_a, dw_a, rd_a};
    assign snap[1] = {pc1_b, pc2_b, pc3_b, dc1_b, dc2_b, dc3_b,
                      ps_b, ds_b, pw_b, dw_b, rd_b};
    assign tp[0] = int'(pwins_a);
    assign td[0] = int'(dwins_a);
    assign tt[0] = int'(ties_a);
    assign tr[0] = int'(rounds_a);
    assign tp[1] = int'(pwins_b);
    assign td[1] = int'(dwins_b);
    assign tt[1] = int'(ties_b);
    assign tr[1] = int'(rounds_b);

    always #5 clk = ~clk;

    function automatic int v(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic bit bdraw(input int d, input int pv, input int r);
        if (r == 0) return d <= 5;
        if (d <= 2) return 1'b1;
        if (d == 3) return pv != 8;
        if (d >= 4 && d <= 6) return pv >= 2 * d - 6 && pv <= 7;
        return 1'b0;
    endfunction

    // Plays the round in cards[] by the casino rules; res 0=player 1=dealer 2=tie
    function automatic logic [34:0] model_hand(input int r, output bit bank,
                                               output int res);
        int p, d, pc3, dc3;
        pc3 = 0;
        dc3 = 0;
        bank = 1'b0;
        p = (v(cards[0]) + v(cards[2])) % 10;
        d = (v(cards[1]) + v(cards[3])) % 10;
        if (p >= 8 || d >= 8) begin
        end else if (p <= 5) begin
            bank = 1'b1;
            pc3 = cards[4];
            if (bdraw(d, v(cards[4]), r)) begin
                dc3 = cards[5];
                d = (d + v(cards[5])) % 10;
            end
            p = (p + v(cards[4])) % 10;
        end else if (d <= 5) begin
            dc3 = cards[4];
            d = (d + v(cards[4])) % 10;
        end
        res = (p > d) ? 0 : (d > p) ? 1 : 2;
        return {4'(cards[0]), 4'(cards[2]), 4'(pc3),
                4'(cards[1]), 4'(cards[3]), 4'(dc3),
                4'(p), 4'(d), res != 1, res != 0, 1'b1};
    endfunction

    task automatic zero_model();
        for (int k = 0; k < 2; k++) begin
            m_pw[k] = 0;
            m_dw[k] = 0;
            m_ti[k] = 0;
            m_rd[k] = 0;
        end
    endtask

    task automatic idle(input int n);
        step = 1'b0;
        repeat (n) begin
            new_card = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
    endtask

    task automatic do_step(input int c);
        step = 1'b1;
        new_card = 4'(c);
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic apply_reset();
        resetb = 1'b0;
        zero_model();
        @(negedge clk);
        resetb = 1'b1;
    endtask

    task automatic run_round(input int first, input string tag);
        bit bank;
        int res [2];
        logic [34:0] exp [2];
        int ep;
        for (int k = 0; k < 2; k++)
            exp[k] = model_hand(rule[k], bank, res[k]);
        for (int i = first; i < 4; i++) begin
            idle($urandom_range(0, 2));
            do_step(cards[i]);
        end
        ep = (v(cards[0]) + v(cards[2])) % 10;
        total++;
        if (int'(ps_a) !== ep)
            $display("FAIL %s eval_pscore: got %0d want %0d", tag, ps_a, ep);
        else
            passed++;
        idle($urandom_range(0, 1));
        do_step(cards[4]);
        if (bank) begin
            idle($urandom_range(0, 1));
            do_step(cards[5]);
        end
        for (int k = 0; k < 2; k++) begin
            if (res[k] == 0 && m_pw[k] < tmax[k]) m_pw[k]++;
            if (res[k] == 1 && m_dw[k] < tmax[k]) m_dw[k]++;
            if (res[k] == 2 && m_ti[k] < tmax[k]) m_ti[k]++;
            if (m_rd[k] < tmax[k]) m_rd[k]++;
            total++;
            if (snap[k] !== exp[k])
                $display("FAIL %s hand dut%0d: got %h want %h",
                         tag, k, snap[k], exp[k]);
            else
                passed++;
            total++;
            if (tp[k] !== m_pw[k] || td[k] !== m_dw[k] ||
                tt[k] !== m_ti[k] || tr[k] !== m_rd[k])
                $display("FAIL %s tally dut%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                         tag, k, tp[k], td[k], tt[k], tr[k],
                         m_pw[k], m_dw[k], m_ti[k], m_rd[k]);
            else
                passed++;
        end
        idle(1);
        total++;
        if (snap[0] !== exp[0])
            $display("FAIL %s done_hold: got %h want %h", tag, snap[0], exp[0]);
        else
            passed++;
        do_step($urandom_range(0, 15));
        for (int k = 0; k < 2; k++) begin
            total++;
            if (snap[k] !== 35'd0 || tr[k] !== m_rd[k])
                $display("FAIL %s clear dut%0d: got %h rounds %0d want 0 rounds %0d",
                         tag, k, snap[k], tr[k], m_rd[k]);
            else
                passed++;
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        zero_model();
        idle(2);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (snap[k] !== 35'd0 || tr[k] !== 0 || tp[k] !== 0)
                $display("FAIL reset dut%0d: got %h rounds %0d want 0",
                         k, snap[k], tr[k]);
            else
                passed++;
        end
        resetb = 1'b1;
        idle(1);
    endtask

    task automatic test_natural();
        cards = '{5, 2, 4, 2, 7, 7};
        run_round(0, "natural");
    endtask

    task automatic test_banker_draw();
        cards = '{2, 3, 3, 3, 7, 1};
        run_round(0, "banker_draw");
    endtask

    task automatic test_banker_stand_tie();
        cards = '{2, 1, 3, 2, 8, 4};
        run_round(0, "stand_tie");
    endtask

    task automatic test_random_rounds();
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 6; i++)
                cards[i] = $urandom_range(0, 15);
            run_round(0, "random");
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        cards = '{9, 13, 12, 11, 0, 0};
        for (int n = 0; n < 5; n++)
            run_round(0, "saturate");
        total++;
        if (pwins_b !== 2'd3 || rounds_b !== 2'd3 ||
            dwins_b !== 2'd0 || ties_b !== 2'd0)
            $display("FAIL sat_narrow: got %0d/%0d/%0d/%0d want 3/0/0/3",
                     pwins_b, dwins_b, ties_b, rounds_b);
        else
            passed++;
        total++;
        if (pwins_a !== 8'd5 || rounds_a !== 8'd5)
            $display("FAIL sat_wide: got %0d/%0d want 5/5", pwins_a, rounds_a);
        else
            passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++)
            cards[i] = $urandom_range(1, 13);
        for (int i = 0; i < 3; i++)
            do_step(cards[i]);
        #1 resetb = 1'b0;
        zero_model();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (snap[k] !== 35'd0 || tr[k] !== 0 || tp[k] !== 0 ||
                td[k] !== 0 || tt[k] !== 0)
                $display("FAIL async_reset dut%0d: got %h rounds %0d want 0",
                         k, snap[k], tr[k]);
            else
                passed++;
        end
        @(negedge clk);
        resetb = 1'b1;
        idle(1);
        do_step(cards[0]);
        total++;
        if (pc1_a !== 4'(cards[0]) || dc1_a !== 4'd0 || pc2_a !== 4'd0)
            $display("FAIL post_reset_p1: got %0d/%0d/%0d want %0d/0/0",
                     pc1_a, dc1_a, pc2_a, cards[0]);
        else
            passed++;
        run_round(1, "after_reset");
    endtask

    task automatic test_auto_mode();
        bit bank;
        int res [2];
        logic [34:0] exp [2];
        int n;
        for (int i = 0; i < 6; i++)
            cards[i] = 10;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 2; k++)
                exp[k] = model_hand(rule[k], bank, res[k]);
            auto_mode = 1'b1;
            new_card = 4'd10;
            for (n = 1; n <= 8; n++) begin
                step = (pass == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
                if (rd_a) break;
            end
            step = 1'b0;
            total++;
            if (n !== 5 + int'(bank))
                $display("FAIL auto_latency pass%0d: got %0d edges want %0d",
                         pass, n, 5 + int'(bank));
            else
                passed++;
            for (int k = 0; k < 2; k++) begin
                if (res[k] == 0 && m_pw[k] < tmax[k]) m_pw[k]++;
                if (res[k] == 1 && m_dw[k] < tmax[k]) m_dw[k]++;
                if (res[k] == 2 && m_ti[k] < tmax[k]) m_ti[k]++;
                if (m_rd[k] < tmax[k]) m_rd[k]++;
                total++;
                if (snap[k] !== exp[k] || tt[k] !== m_ti[k] ||
                    tr[k] !== m_rd[k])
                    $display("FAIL auto_done dut%0d: got %h ties %0d want %h ties %0d",
                             k, snap[k], tt[k], exp[k], m_ti[k]);
                else
                    passed++;
            end
            @(negedge clk);
            auto_mode = 1'b0;
            total++;
            if (snap[0] !== 35'd0 || snap[1] !== 35'd0)
                $display("FAIL auto_clear: got %h %h want 0", snap[0], snap[1]);
            else
                passed++;
            idle(1);
        end
    endtask

    initial begin
        test_reset();
        test_natural();
        test_banker_draw();
        test_banker_stand_tie();
        test_random_rounds();
        test_auto_mode();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
